// File: rtl/digit_serial_pkg.sv
// -----------------------------------------------------------------------------
// digit_serial_pkg
// Shared definitions for the digit-serial adder:
//   WIDTH_DEF / DIGIT_DEF : default operand width and bits added per cycle
//   NDIG_DEF              : digits per operand (cycles spent in RUN)
//   CNT_W_DEF             : width of the digit counter for the defaults
//   state_t, S_*          : FSM state encoding
//   cnt_width()           : digit-counter width for any digit count
// -----------------------------------------------------------------------------
package digit_serial_pkg;

   localparam int WIDTH_DEF = 12;
   localparam int DIGIT_DEF = 3;
   localparam int NDIG_DEF  = WIDTH_DEF / DIGIT_DEF;

   // A counter for a single digit still needs one bit to exist.
   function automatic int cnt_width(input int ndig);
      return (ndig > 1) ? $clog2(ndig) : 1;
   endfunction

   localparam int CNT_W_DEF = cnt_width(NDIG_DEF);

   typedef logic [1:0] state_t;

   localparam state_t S_IDLE = 2'd0;
   localparam state_t S_RUN  = 2'd1;
   localparam state_t S_DONE = 2'd2;

endpackage

// File: rtl/cla_digit.sv
// -----------------------------------------------------------------------------
// cla_digit
// Combinational DIGIT-bit carry look-ahead adder slice.
// Ports:
//   x, y : DIGIT-bit addends
//   ci   : carry in
//   s    : DIGIT-bit sum
//   co   : carry out of the top bit
// Every carry is expanded into its full generate/propagate sum-of-products,
// so no carry depends on another carry of the same slice.
// -----------------------------------------------------------------------------
module cla_digit #(
   parameter int DIGIT = 3
) (
   input  logic [DIGIT-1:0] x,
   input  logic [DIGIT-1:0] y,
   input  logic             ci,
   output logic [DIGIT-1:0] s,
   output logic             co
);

   logic [DIGIT-1:0] g;
   logic [DIGIT-1:0] p;
   logic [DIGIT:0]   c;

   assign g = x & y;
   assign p = x ^ y;

   // NOTE: every variable written in always_comb gets a default first, so no
   // path through the block leaves it unassigned and infers a latch.
   always_comb begin
      logic term_c;
      logic term_p;
      c = '0;
      c[0] = ci;
      for (int i = 0; i < DIGIT; i++) begin
         // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i]..p[0]ci
         term_c = 1'b0;
         term_p = 1'b1;
         for (int j = i; j >= 0; j--) begin
            term_c = term_c | (term_p & g[j]);
            term_p = term_p & p[j];
         end
         c[i+1] = term_c | (term_p & ci);
      end
   end

   assign s  = p ^ c[DIGIT-1:0];
   assign co = c[DIGIT];

endmodule

// File: rtl/digit_serial_adder.sv
// -----------------------------------------------------------------------------
// digit_serial_adder
// Adds two WIDTH-bit operands plus a carry-in, DIGIT bits per clock, through a
// single carry look-ahead slice. Handshaked operand input and result output.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid, in_ready  : operand handshake (in_ready only in IDLE)
//   a, b, cin           : operands and carry into bit 0
//   out_valid, out_ready: result handshake (out_valid only in DONE)
//   sum, cout           : (a+b+cin) mod 2^WIDTH and carry out of bit WIDTH-1;
//                         held from DONE until the next result completes
//   busy                : FSM is not in IDLE
// Timing: accepted at cycle T, RUN during T+1..T+NDIG, out_valid from
// T+1+NDIG. The earliest next accept is the cycle after the drain.
// -----------------------------------------------------------------------------
module digit_serial_adder
   import digit_serial_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int DIGIT = DIGIT_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy
);

   localparam int NDIG  = (DIGIT > 0) ? (WIDTH / DIGIT) : 1;
   localparam int CNT_W = cnt_width(NDIG);
   localparam logic [CNT_W-1:0] LAST_DIG = CNT_W'(NDIG - 1);

   // Configuration guards, evaluated at elaboration.
   if ((DIGIT < 1) ? 1'b1 : ((WIDTH % DIGIT) != 0)) begin : g_bad_cfg
      $error("digit_serial_adder: WIDTH (%0d) must be a positive multiple of DIGIT (%0d)",
             WIDTH, DIGIT);
   end
   if (WIDTH == WIDTH_DEF && DIGIT == DIGIT_DEF &&
       (NDIG != NDIG_DEF || CNT_W != CNT_W_DEF)) begin : g_pkg_mismatch
      $error("digit_serial_adder: derived constants disagree with digit_serial_pkg");
   end

   state_t           state_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             carry_q;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] acc_q;    // partial sum being assembled during RUN
   logic [WIDTH-1:0] sum_q;    // visible result, only replaced on completion
   logic             cout_q;

   logic [DIGIT-1:0] dig_s;
   logic             dig_co;
   logic [WIDTH-1:0] acc_next;

   cla_digit #(
      .DIGIT (DIGIT)
   ) u_cla (
      .x  (a_q[DIGIT-1:0]),
      .y  (b_q[DIGIT-1:0]),
      .ci (carry_q),
      .s  (dig_s),
      .co (dig_co)
   );

   // Partial sum with the current digit dropped into place; on the last
   // digit this is the complete result.
   always_comb begin
      acc_next = acc_q;
      acc_next[cnt_q*DIGIT +: DIGIT] = dig_s;
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         acc_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  a_q     <= a;
                  b_q     <= b;
                  carry_q <= cin;
                  cnt_q   <= '0;
                  acc_q   <= '0;
                  state_q <= S_RUN;
               end
            end
            S_RUN: begin
               acc_q   <= acc_next;
               carry_q <= dig_co;
               a_q     <= a_q >> DIGIT;
               b_q     <= b_q >> DIGIT;
               cnt_q   <= cnt_q + 1'b1;
               if (cnt_q == LAST_DIG) begin
                  sum_q   <= acc_next;
                  cout_q  <= dig_co;
                  cnt_q   <= '0;
                  state_q <= S_DONE;
               end
            end
            S_DONE: begin
               // Drain only; operands offered now are not looked at.
               if (out_ready) begin
                  state_q <= S_IDLE;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign busy      = (state_q != S_IDLE);
   assign sum       = sum_q;
   assign cout      = cout_q;

endmodule

// File: tb/tb_digit_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_digit_serial_adder
// Self-checking bench for digit_serial_adder (WIDTH=12, DIGIT=3).
// Inputs change 1 time unit after a rising edge; outputs are sampled on the
// falling edge. Expected results enter a queue at operand accept and leave it
// when the DUT hands a result over.
// -----------------------------------------------------------------------------
module tb_digit_serial_adder;

   localparam int WIDTH = 12;
   localparam int DIGIT = 3;
   localparam int LAT   = 5;   // accept cycle to first out_valid cycle
   localparam int ISSUE = 6;   // accept-to-accept interval when streaming

   typedef struct {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic             cin;
      logic [WIDTH-1:0] sum;
      logic             cout;
   } vec_t;

   typedef struct {
      logic [WIDTH-1:0] sum;
      logic             cout;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             busy;

   int   n_vec   = 0;
   int   n_err   = 0;
   int   cycle   = 0;
   int   acc_cyc = 0;
   logic prev_ov = 1'b0;
   exp_t sb[$];
   vec_t tbl[8];

   digit_serial_adder #(
      .WIDTH (WIDTH),
      .DIGIT (DIGIT)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cycle);
      end
   endtask

   function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                  input logic c);
      logic [WIDTH:0] t;
      exp_t e;
      t = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
      e.sum  = t[WIDTH-1:0];
      e.cout = t[WIDTH];
      return e;
   endfunction

   // Result monitor: latency on each new out_valid, data on each drain.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (out_valid && !prev_ov) begin
            check("latency", 64'(cycle - acc_cyc), 64'(LAT));
         end
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_result: got sum 0x%0h with no operands pending", sum);
            end else begin
               e = sb.pop_front();
               check("sum", 64'(sum), 64'(e.sum));
               check("cout", 64'(cout), 64'(e.cout));
            end
         end
      end
      prev_ov <= out_valid;
   end

   // Offers one operand set, records its expected result at accept.
   task automatic send(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb,
                       input logic xc, input logic [WIDTH-1:0] es, input logic ec);
      exp_t e;
      int   n;
      a        = xa;
      b        = xb;
      cin      = xc;
      in_valid = 1'b1;
      n        = 0;
      @(negedge clk);
      while (!in_ready && n < 20) begin
         n++;
         @(negedge clk);
      end
      if (!in_ready) begin
         n_vec++;
         n_err++;
         $display("FAIL accept_timeout: in_ready stayed 0, expected 1");
      end else begin
         e.sum  = es;
         e.cout = ec;
         sb.push_back(e);
         acc_cyc = cycle;
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic wait_empty(input int budget);
      int n;
      n = 0;
      while (sb.size() != 0 && n < budget) begin
         n++;
         @(posedge clk);
      end
      #1;
      if (sb.size() != 0) begin
         n_vec++;
         n_err++;
         $display("FAIL drain_timeout: %0d results pending, expected 0", sb.size());
         sb.delete();
      end
   endtask

   initial begin
      int   n;
      int   accepts;
      int   last_acc;
      exp_t e;

      tbl[0] = '{a: 12'h000, b: 12'h000, cin: 1'b0, sum: 12'h000, cout: 1'b0};
      tbl[1] = '{a: 12'hFFF, b: 12'h001, cin: 1'b0, sum: 12'h000, cout: 1'b1};
      tbl[2] = '{a: 12'hABC, b: 12'h123, cin: 1'b1, sum: 12'hBE0, cout: 1'b0};
      tbl[3] = '{a: 12'hFFF, b: 12'hFFF, cin: 1'b1, sum: 12'hFFF, cout: 1'b1};
      tbl[4] = '{a: 12'h800, b: 12'h800, cin: 1'b0, sum: 12'h000, cout: 1'b1};
      tbl[5] = '{a: 12'h0FF, b: 12'h001, cin: 1'b0, sum: 12'h100, cout: 1'b0};
      tbl[6] = '{a: 12'h7FF, b: 12'h000, cin: 1'b1, sum: 12'h800, cout: 1'b0};
      tbl[7] = '{a: 12'h249, b: 12'h492, cin: 1'b0, sum: 12'h6DB, cout: 1'b0};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      a         = '0;
      b         = '0;
      cin       = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Reset state, first cycle after release.
      @(negedge clk);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_sum", 64'(sum), 64'd0);
      check("rst_cout", 64'(cout), 64'd0);
      @(posedge clk);
      #1;

      // Table vectors, one at a time.
      for (int i = 0; i < 8; i++) begin
         send(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sum, tbl[i].cout);
         wait_empty(30);
      end

      // Back-pressure in DONE with new operands offered.
      out_ready = 1'b0;
      send(12'h111, 12'h222, 1'b0, 12'h333, 1'b0);
      n = 0;
      @(negedge clk);
      while (!out_valid && n < 20) begin
         n++;
         @(negedge clk);
      end
      check("stall_out_valid_seen", 64'(out_valid), 64'd1);
      in_valid = 1'b1;
      a        = 12'h555;
      b        = 12'h0AA;
      cin      = 1'b1;
      for (int k = 0; k < 3; k++) begin
         check("stall_out_valid", 64'(out_valid), 64'd1);
         check("stall_in_ready", 64'(in_ready), 64'd0);
         check("stall_sum", 64'(sum), 64'h333);
         check("stall_cout", 64'(cout), 64'd0);
         if (k < 2) @(negedge clk);
      end
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      check("drain_out_valid", 64'(out_valid), 64'd1);
      check("drain_sum", 64'(sum), 64'h333);
      @(negedge clk);
      check("post_drain_in_ready", 64'(in_ready), 64'd1);
      check("post_drain_busy", 64'(busy), 64'd0);
      check("post_drain_out_valid", 64'(out_valid), 64'd0);
      check("post_drain_sum_kept", 64'(sum), 64'h333);
      check("post_drain_cout_kept", 64'(cout), 64'd0);
      check("post_drain_queue", 64'(sb.size()), 64'd0);
      @(posedge clk);
      #1;

      // Reset while digit 2 is being added.
      send(12'h0F0, 12'h00F, 1'b1, 12'h100, 1'b0);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1 rst_n = 1'b0;
      @(negedge clk);
      check("run_busy", 64'(busy), 64'd1);
      @(posedge clk);
      #1 rst_n = 1'b1;
      sb.delete();
      @(negedge clk);
      check("mid_rst_in_ready", 64'(in_ready), 64'd1);
      check("mid_rst_out_valid", 64'(out_valid), 64'd0);
      check("mid_rst_busy", 64'(busy), 64'd0);
      check("mid_rst_sum", 64'(sum), 64'd0);
      check("mid_rst_cout", 64'(cout), 64'd0);
      repeat (8) @(negedge clk);
      check("mid_rst_no_result", 64'(out_valid), 64'd0);
      @(posedge clk);
      #1;

      // Continuous stream: in_valid and out_ready held high.
      a         = 12'hFF8;
      b         = 12'h7F0;
      cin       = 1'b0;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      accepts   = 0;
      last_acc  = -1;
      for (int c = 0; c < 80 && accepts < 8; c++) begin
         @(negedge clk);
         if (in_ready) begin
            if (last_acc >= 0) check("issue_interval", 64'(cycle - last_acc), 64'(ISSUE));
            last_acc = cycle;
            acc_cyc  = cycle;
            accepts++;
            e = model(a, b, cin);
            sb.push_back(e);
            @(posedge clk);
            #1;
            a   = a + 12'd1;
            b   = b + 12'd3;
            cin = ~cin;
         end
      end
      in_valid = 1'b0;
      if (accepts < 8) begin
         n_vec++;
         n_err++;
         $display("FAIL stream_accepts: got %0d, expected 8", accepts);
      end
      wait_empty(30);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/digit_serial_adder.md
DIGIT_SERIAL_ADDER -- requirements
Module: digit_serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 12, meaning operand and sum width in bits.
REQ-002 SHALL have parameter DIGIT, default 3, meaning bits added per cycle by the look-ahead slice.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset that is synchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1, meaning an operand set is offered.
REQ-006 SHALL have port in_ready, output, 1, meaning the block accepts operands this cycle.
REQ-007 SHALL have port a, input, WIDTH, meaning the first operand.
REQ-008 SHALL have port b, input, WIDTH, meaning the second operand.
REQ-009 SHALL have port cin, input, 1, meaning the carry into bit 0.
REQ-010 SHALL have port out_valid, output, 1, meaning sum and cout hold a completed result.
REQ-011 SHALL have port out_ready, input, 1, meaning the consumer takes the result.
REQ-012 SHALL have port sum, output, WIDTH, meaning (a+b+cin) mod 2^WIDTH.
REQ-013 SHALL have port cout, output, 1, meaning the carry out of bit WIDTH-1.
REQ-014 SHALL have port busy, output, 1, meaning the FSM is not in IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DONE; NDIG = WIDTH/DIGIT (4 by default).
REQ-016 In IDLE: in_ready=1, out_valid=0, busy=0.
REQ-017 On in_valid&in_ready in cycle T: capture a, b into operand shift registers, cin into the carry register, clear the digit counter, go to RUN.
REQ-018 In RUN cycle T+1+k (k=0..NDIG-1): add the low DIGIT bits of both shift registers plus the carry register through the look-ahead slice, place the result digit at bits [k*DIGIT +: DIGIT] of the sum register, store the slice carry-out, shift operands right by DIGIT.
REQ-019 After digit NDIG-1 go to DONE; out_valid SHALL be 1 from cycle T+1+NDIG (T+5 by default); cout equals the final carry register.
REQ-020 In DONE: sum and cout held stable; in_ready=0; when out_valid&out_ready, go to IDLE next cycle.
REQ-021 No same-cycle result-drain and operand-accept; minimum issue interval is NDIG+2 cycles (6 by default).
REQ-022 in_valid and operands outside IDLE SHALL be ignored and SHALL NOT disturb the in-flight computation.
REQ-023 sum and cout SHALL keep the last result after returning to IDLE until the next DONE overwrites them.
REQ-024 Overflow wraps modulo 2^WIDTH; only cout reports it; no saturation.
REQ-025 WIDTH not a multiple of DIGIT, or DIGIT<1, SHALL be an elaboration error.

Reset
REQ-026 When rst_n=0 at a rising edge: state=IDLE, sum=0, cout=0, carry register=0, digit counter=0, operand registers=0.
REQ-027 Reset SHALL override any state including RUN and DONE; the partial result is discarded, and out_valid=0, in_ready=1 in the cycle after reset is released.

Structure
REQ-028 Package digit_serial_pkg SHALL hold default WIDTH, DIGIT, derived NDIG, counter width, and the FSM state typedef.
REQ-029 Sub-module cla_digit SHALL be the combinational DIGIT-bit carry look-ahead slice (generate/propagate form, inputs x, y, ci; outputs s, co), instantiated once.

Verification
REQ-030 a=0x000, b=0x000, cin=0 accepted at T -> out_valid at T+5, sum=0x000, cout=0.
REQ-031 a=0xFFF, b=0x001, cin=0 -> sum=0x000, cout=1 (carry crosses all four digits).
REQ-032 a=0xABC, b=0x123, cin=1 -> sum=0xBE0, cout=0.
REQ-033 Result ready, out_ready=0 for 3 cycles, in_valid=1 with a=0x555 -> out_valid, sum, cout held, in_ready=0, new operands ignored; drain on cycle 4, IDLE next.
REQ-034 rst_n=0 for one cycle during RUN digit 2 -> next cycle IDLE, out_valid=0, in_ready=1, sum=0, cout=0.
REQ-035 in_valid=1 and out_ready=1 held with an incrementing operand stream -> exactly one accept and one result every 6 cycles, all sums correct against a+b+cin.
